axi_rd_arbiter_mux: RTL



---
 rtl/axi_rd_pkg.sv | 22 ++
 rtl/rr_arbiter4.sv | 38 +++
 rtl/axi_rd_arbiter_mux.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_pkg
// Description : Shared constants and types for the read-side arbiter/mux.
//               Holds the controller-facing field widths, the master count
//               and the AR-channel FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int CTRL_ADDR_W = 28;
    localparam int CTRL_LEN_W  = 4;
    localparam int CTRL_ID_W   = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ADDR = 1'b1
    } rd_state_t;

endpackage : axi_rd_pkg
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-way combinational round-robin arbiter. The search for
//               the next requester begins one position after the last grant
//               and wraps. The last-grant pointer register lives in the parent.
// Ports       : i_req        - request vector, bit N = master N
//               i_last_grant - index of the most recent grant
//               o_grant      - selected master index
//               o_any_req    - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_any_req
);

    logic [1:0] w_idx;

    // Walk from the farthest candidate to the nearest so that the nearest
    // requester after the last grant overwrites any earlier match.
    always_comb begin
        o_grant = i_last_grant;
        w_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = i_last_grant + 2'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule : rr_arbiter4
`default_nettype wire

// File: rtl/axi_rd_arbiter_mux.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_arbiter_mux
// Description : Arbitrates the AR channels of four read masters onto a single
//               DDR-controller read port and routes returning R beats back
//               to the originating master using axi_rid[1:0].
//               Optional macro AXI_RD_PIPE_EN registers the R path (one cycle
//               latency); when undefined the R path is combinational.
// Ports       : ACLK, ARESETn            - clock, async active-low reset
//               sN_AR*  (N=0..3)         - master address channels
//               sN_R*   (N=0..3)         - master read-data channels
//               axi_ar*                  - controller address channel
//               axi_r*                   - controller read-data channel
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter_mux
    import axi_rd_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,

    input  logic [ID_WIDTH-1:0]    s0_ARID,
    input  logic [ADDR_WIDTH-1:0]  s0_ARADDR,
    input  logic [7:0]             s0_ARLEN,
    input  logic                   s0_ARVALID,
    output logic                   s0_ARREADY,
    output logic                   s0_RVALID,
    output logic [DATA_WIDTH-1:0]  s0_RDATA,
    output logic                   s0_RLAST,

    input  logic [ID_WIDTH-1:0]    s1_ARID,
    input  logic [ADDR_WIDTH-1:0]  s1_ARADDR,
    input  logic [7:0]             s1_ARLEN,
    input  logic                   s1_ARVALID,
    output logic                   s1_ARREADY,
    output logic                   s1_RVALID,
    output logic [DATA_WIDTH-1:0]  s1_RDATA,
    output logic                   s1_RLAST,

    input  logic [ID_WIDTH-1:0]    s2_ARID,
    input  logic [ADDR_WIDTH-1:0]  s2_ARADDR,
    input  logic [7:0]             s2_ARLEN,
    input  logic                   s2_ARVALID,
    output logic                   s2_ARREADY,
    output logic                   s2_RVALID,
    output logic [DATA_WIDTH-1:0]  s2_RDATA,
    output logic                   s2_RLAST,

    input  logic [ID_WIDTH-1:0]    s3_ARID,
    input  logic [ADDR_WIDTH-1:0]  s3_ARADDR,
    input  logic [7:0]             s3_ARLEN,
    input  logic                   s3_ARVALID,
    output logic                   s3_ARREADY,
    output logic                   s3_RVALID,
    output logic [DATA_WIDTH-1:0]  s3_RDATA,
    output logic                   s3_RLAST,

    output logic [CTRL_ADDR_W-1:0] axi_araddr,
    output logic                   axi_aruser_ap,
    output logic [CTRL_ID_W-1:0]   axi_aruser_id,
    output logic [CTRL_LEN_W-1:0]  axi_arlen,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    input  logic [DATA_WIDTH-1:0]  axi_rdata,
    input  logic [CTRL_ID_W-1:0]   axi_rid,
    input  logic                   axi_rlast,
    input  logic                   axi_rvalid
);

    localparam logic [3:0] C_MAX_OUT = 4'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------
    // Gather per-master ports into arrays
    // ------------------------------------------------------------------
    logic [NUM_MASTERS-1:0] w_arvalid;
    logic [ADDR_WIDTH-1:0]  w_araddr [NUM_MASTERS];
    logic [7:0]             w_arlen  [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_arready;
    logic [NUM_MASTERS-1:0] w_rvalid;
    logic [NUM_MASTERS-1:0] w_rlast;
    logic [DATA_WIDTH-1:0]  w_rdata  [NUM_MASTERS];

    assign w_arvalid   = {s3_ARVALID, s2_ARVALID, s1_ARVALID, s0_ARVALID};
    assign w_araddr[0] = s0_ARADDR;
    assign w_araddr[1] = s1_ARADDR;
    assign w_araddr[2] = s2_ARADDR;
    assign w_araddr[3] = s3_ARADDR;
    assign w_arlen[0]  = s0_ARLEN;
    assign w_arlen[1]  = s1_ARLEN;
    assign w_arlen[2]  = s2_ARLEN;
    assign w_arlen[3]  = s3_ARLEN;

    assign s0_ARREADY = w_arready[0];
    assign s1_ARREADY = w_arready[1];
    assign s2_ARREADY = w_arready[2];
    assign s3_ARREADY = w_arready[3];
    assign s0_RVALID  = w_rvalid[0];
    assign s1_RVALID  = w_rvalid[1];
    assign s2_RVALID  = w_rvalid[2];
    assign s3_RVALID  = w_rvalid[3];
    assign s0_RLAST   = w_rlast[0];
    assign s1_RLAST   = w_rlast[1];
    assign s2_RLAST   = w_rlast[2];
    assign s3_RLAST   = w_rlast[3];
    assign s0_RDATA   = w_rdata[0];
    assign s1_RDATA   = w_rdata[1];
    assign s2_RDATA   = w_rdata[2];
    assign s3_RDATA   = w_rdata[3];

    // IDs, upper address bits and upper length bits are not forwarded.
    logic w_unused_ok;
    assign w_unused_ok = ^{s0_ARID, s1_ARID, s2_ARID, s3_ARID,
                           s0_ARADDR[ADDR_WIDTH-1:CTRL_ADDR_W],
                           s1_ARADDR[ADDR_WIDTH-1:CTRL_ADDR_W],
                           s2_ARADDR[ADDR_WIDTH-1:CTRL_ADDR_W],
                           s3_ARADDR[ADDR_WIDTH-1:CTRL_ADDR_W],
                           s0_ARLEN[7:4], s1_ARLEN[7:4],
                           s2_ARLEN[7:4], s3_ARLEN[7:4]};

    // ------------------------------------------------------------------
    // Arbiter and AR-channel FSM
    // ------------------------------------------------------------------
    rd_state_t  r_state;
    rd_state_t  w_state_nxt;
    logic [1:0] r_grant;
    logic [1:0] r_rr_ptr;
    logic [1:0] w_arb_grant;
    logic       w_any_req;
    logic       w_grant_load;
    logic [3:0] r_outstanding;
    logic       w_ar_hs;
    logic       w_r_done;

    rr_arbiter4 u_rr_arbiter4 (
        .i_req        (w_arvalid),
        .i_last_grant (r_rr_ptr),
        .o_grant      (w_arb_grant),
        .o_any_req    (w_any_req)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        axi_arvalid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req && (r_outstanding < C_MAX_OUT)) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = ADDR;
                end
            end
            ADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The pointer resets to 3 so that the first search after reset starts
    // at master 0, while the visible grant resets to 0.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_grant  <= 2'd0;
            r_rr_ptr <= 2'd3;
        end else if (w_grant_load) begin
            r_grant  <= w_arb_grant;
            r_rr_ptr <= w_arb_grant;
        end
    end

    assign axi_araddr    = w_araddr[r_grant][CTRL_ADDR_W-1:0];
    assign axi_arlen     = w_arlen[r_grant][CTRL_LEN_W-1:0];
    assign axi_aruser_id = {2'b00, r_grant};
    assign axi_aruser_ap = 1'b1;

    // ------------------------------------------------------------------
    // Outstanding-burst counter. A stale rlast arriving at zero (e.g. a
    // burst issued before reset) must not wrap the counter.
    // ------------------------------------------------------------------
    assign w_ar_hs  = (r_state == ADDR) && axi_arready;
    assign w_r_done = axi_rvalid && axi_rlast && (r_outstanding != 4'd0);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_outstanding <= 4'd0;
        end else begin
            case ({w_ar_hs, w_r_done})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Per-master AR ready and R routing. Beats whose rid[3:2] is non-zero
    // belong to no master here and are silently dropped.
    // ------------------------------------------------------------------
    for (genvar n = 0; n < NUM_MASTERS; n++) begin : g_lane
        logic w_hit;

        assign w_arready[n] = (r_state == ADDR) && (r_grant == 2'(n)) && axi_arready;
        assign w_hit        = axi_rvalid && (axi_rid[1:0] == 2'(n)) && (axi_rid[3:2] == 2'b00);

`ifdef AXI_RD_PIPE_EN
        logic                  r_rvalid;
        logic                  r_rlast;
        logic [DATA_WIDTH-1:0] r_rdata;

        // Data is captured only in the lane being served, so idle lanes
        // keep their last delivered beat.
        always_ff @(posedge ACLK or negedge ARESETn) begin
            if (!ARESETn) begin
                r_rvalid <= 1'b0;
                r_rlast  <= 1'b0;
                r_rdata  <= '0;
            end else begin
                r_rvalid <= w_hit;
                r_rlast  <= w_hit && axi_rlast;
                if (w_hit) begin
                    r_rdata <= axi_rdata;
                end
            end
        end

        assign w_rvalid[n] = r_rvalid;
        assign w_rlast[n]  = r_rlast;
        assign w_rdata[n]  = r_rdata;
`else
        assign w_rvalid[n] = w_hit;
        assign w_rlast[n]  = axi_rlast;
        assign w_rdata[n]  = axi_rdata;
`endif
    end : g_lane

endmodule : axi_rd_arbiter_mux
`default_nettype wire
